instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Instruction fetch stage feeding the decoder. Holds the PC and issues word
//  requests to instruction memory over a req/ack handshake. Presents the
//  fetched word as InstrReg with a valid/ready handshake to the decoder.
//  Computes the jump/branch targets and redirects the PC on the control-unit
//  redirect pulse.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC value loaded on reset
//  IMEM_AW     32             width of imem_addr (byte address, word aligned)
// PORTS
//  clk          in   1   single clock, rising edge
//  rst          in   1   synchronous, active-high reset
//  imem_req     out  1   request; held high until imem_ack
//  imem_addr    out  32  byte address of request, bits[1:0]=00
//  imem_ack     in   1   one-cycle pulse, imem_rdata valid same cycle
//  imem_rdata   in   32  instruction word
//  InstrReg     out  32  instruction to decoder
//  InstrPC      out  32  PC of InstrReg
//  instr_valid  out  1   InstrReg/InstrPC valid
//  dec_ready    in   1   decoder accepts when instr_valid&dec_ready
//  redirect     in   1   one-cycle: take target selected by redir_sel
//  redir_sel    in   1   0=branch, 1=jump
//  redir_pc     in   32  PC of the redirecting instruction
//  redir_const  in   16  branch immediate (decoder const field)
//  redir_addr   in   26  jump address (decoder address field)
//  fetch_cnt    out  32  count of instructions handed to decoder
// BEHAVIOUR
//  Reset (sync, rst=1 at edge): pc<=RESET_PC; state<=IDLE; imem_req=0,
//   instr_valid=0, InstrReg=0, InstrPC=0, fetch_cnt=0, discard=0.
//   Reset wins over every other input, including mid-request.
//  FSM states:
//   IDLE  -> FETCH next cycle (one bubble after reset).
//   FETCH: imem_req=1, imem_addr=pc. On ack and not discard, latch rdata into
//          InstrReg and pc into InstrPC, instr_valid<=1, pc<=pc+4, go to HOLD.
//   HOLD:  instr_valid=1. On dec_ready: fetch_cnt++. If imem_ack arrives in
//          the same cycle, refill; else instr_valid<=0 and return to FETCH
//          (issue, not wait, for one-cycle throughput).
//  Latency: ack in cycle N -> instr_valid in N+1. Back-to-back: 1 instr/cycle
//   when ack arrives every cycle and dec_ready=1.
//  Targets (32-bit, wrap mod 2^32, no overflow flag):
//   branch = redir_pc + 4 + {{14{c[15]}}, c, 2'b00}
//   jump   = {(redir_pc+4)[31:28], redir_addr, 2'b00}
//  Redirect (any state): pc<=target; instr_valid<=0 (held word flushed,
//   fetch_cnt not incremented even if dec_ready same cycle); state<=FETCH.
//   If a request is outstanding (FETCH, no ack this cycle), set discard=1; the
//   next ack is dropped and clears discard, then the target is requested.
//   Redirect in the same cycle as ack: the ack data is dropped, discard stays 0.
//  imem_addr/imem_req are stable while imem_req=1 and no ack (except redirect
//   with discard, where addr stays on the old PC until its ack).
//  Bits[1:0] of redir_pc are ignored (treated as 00).
// STRUCTURE
//  Shared package: IF_IDLE/IF_FETCH/IF_HOLD state encodings, RESET_PC default,
//   OPC_J/OPC_BEQ opcode constants shared with decoder and control.
//  One sub-module: if_target_calc (combinational branch/jump target adder).
// TESTING
//  Reset then ack every cycle, dec_ready=1 -> addrs 0,4,8,...; InstrPC
//   matches; fetch_cnt=3 after third accept.
//  Hold dec_ready=0 for 5 cycles in HOLD -> InstrReg stable, no new imem_req,
//   fetch_cnt unchanged.
//  redirect, sel=1, redir_pc=32'h0040_0010, addr=26'h000_0100 -> next
//   imem_addr=32'h0000_0400, held instr flushed.
//  Branch: redir_pc=32'h100, const=16'hFFFE -> imem_addr=32'hFC.
//  Redirect in FETCH with ack delayed 3 cycles -> stale ack data never
//   reaches InstrReg; the following request addr equals the target.
//  rst asserted mid-FETCH -> next cycle imem_req=0, pc=RESET_PC,
//   instr_valid=0, fetch_cnt=0.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage definitions: FSM state encodings, reset PC default,
// opcode constants shared with decoder/control, and the held-instruction record.
package instr_fetch_pkg;

  localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;

  localparam logic [5:0] OPC_J   = 6'h02;
  localparam logic [5:0] OPC_BEQ = 6'h04;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_FETCH = 2'd1,
    IF_HOLD  = 2'd2
  } if_state_e;

  // Word handed to the decoder together with the PC it was fetched from.
  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } if_instr_t;

  // Low two address bits carry no information for word fetches.
  function automatic logic [31:0] if_word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/instr_fetch_target_calc.sv
// Combinational redirect target.
//   redir_pc    : PC of the redirecting instruction (bits[1:0] ignored)
//   redir_sel   : 0 = branch, 1 = jump
//   redir_const : branch immediate, word offset relative to pc+4
//   redir_addr  : jump word address within the current 256MB region
//   target      : selected target, arithmetic wraps mod 2^32
module if_target_calc
  import instr_fetch_pkg::*;
(
  input  logic [31:0] redir_pc,
  input  logic        redir_sel,
  input  logic [15:0] redir_const,
  input  logic [25:0] redir_addr,
  output logic [31:0] target
);

  logic [31:0] pc4;
  logic [31:0] boff;

  always_comb begin
    pc4    = if_word_align(redir_pc) + 32'd4;
    boff   = {{14{redir_const[15]}}, redir_const, 2'b00};
    target = redir_sel ? {pc4[31:28], redir_addr, 2'b00} : (pc4 + boff);
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage.
//   clk, rst          : clock, synchronous active-high reset
//   imem_req/addr     : word request to instruction memory, held until ack
//   imem_ack/rdata    : one-cycle ack with data
//   InstrReg/InstrPC  : fetched word and its PC, qualified by instr_valid
//   dec_ready         : decoder accepts on instr_valid & dec_ready
//   redirect/redir_*  : one-cycle PC redirect (branch or jump)
//   fetch_cnt         : instructions accepted by the decoder
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IF_RESET_PC,
  parameter int          IMEM_AW  = 32
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        InstrReg,
  output logic [31:0]        InstrPC,
  output logic               instr_valid,
  input  logic               dec_ready,
  input  logic               redirect,
  input  logic               redir_sel,
  input  logic [31:0]        redir_pc,
  input  logic [15:0]        redir_const,
  input  logic [25:0]        redir_addr,
  output logic [31:0]        fetch_cnt
);

  if_state_e   state, state_n;
  logic [31:0] pc;
  logic [31:0] stale_addr;
  logic        discard;
  if_instr_t   held;
  logic [31:0] target;
  logic [31:0] addr_full;

  logic load;       // capture imem_rdata into the held slot
  logic accept;     // decoder takes the held word
  logic clr_valid;  // held word consumed with no refill
  logic clr_disc;   // stale ack has arrived

  if_target_calc u_tgt (
    .redir_pc    (redir_pc),
    .redir_sel   (redir_sel),
    .redir_const (redir_const),
    .redir_addr  (redir_addr),
    .target      (target)
  );

  // While a pre-redirect request is still in flight the bus must keep
  // showing its original address; pc already holds the new target.
  assign addr_full = discard ? stale_addr : pc;
  assign imem_addr = addr_full[IMEM_AW-1:0];
  assign InstrReg  = held.word;
  assign InstrPC   = held.pc;

  always_ff @(posedge clk) begin
    if (rst) state <= IF_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    imem_req  = 1'b0;
    load      = 1'b0;
    accept    = 1'b0;
    clr_valid = 1'b0;
    clr_disc  = 1'b0;
    case (state)
      IF_IDLE: state_n = IF_FETCH;
      IF_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          if (discard) begin
            clr_disc = 1'b1;
          end else begin
            load    = 1'b1;
            state_n = IF_HOLD;
          end
        end
      end
      IF_HOLD: begin
        // Request the next word in the same cycle the decoder drains this
        // one, so a same-cycle ack sustains one instruction per cycle.
        if (dec_ready) begin
          imem_req = 1'b1;
          accept   = 1'b1;
          if (imem_ack) begin
            load = 1'b1;
          end else begin
            clr_valid = 1'b1;
            state_n   = IF_FETCH;
          end
        end
      end
      default: state_n = IF_IDLE;
    endcase
    if (redirect) state_n = IF_FETCH;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      stale_addr  <= '0;
      discard     <= 1'b0;
      held        <= '0;
      instr_valid <= 1'b0;
      fetch_cnt   <= '0;
    end else if (redirect) begin
      // Held word and any same-cycle ack data are dropped.
      pc          <= target;
      instr_valid <= 1'b0;
      if (imem_req && !imem_ack) begin
        discard    <= 1'b1;
        stale_addr <= addr_full;
      end else begin
        discard    <= 1'b0;
      end
    end else begin
      if (load) begin
        held        <= '{word: imem_rdata, pc: pc};
        instr_valid <= 1'b1;
        pc          <= pc + 32'd4;
      end else if (clr_valid) begin
        instr_valid <= 1'b0;
      end
      if (clr_disc) discard   <= 1'b0;
      if (accept)   fetch_cnt <= fetch_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] InstrReg;
  logic [31:0] InstrPC;
  logic        instr_valid;
  logic        dec_ready;
  logic        redirect;
  logic        redir_sel;
  logic [31:0] redir_pc;
  logic [15:0] redir_const;
  logic [25:0] redir_addr;
  logic [31:0] fetch_cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ack_log[$];
  int          mem_lat = 0;
  int          lat_cnt = 0;
  bit          drop_pending = 1'b0;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .InstrReg    (InstrReg),
    .InstrPC     (InstrPC),
    .instr_valid (instr_valid),
    .dec_ready   (dec_ready),
    .redirect    (redirect),
    .redir_sel   (redir_sel),
    .redir_pc    (redir_pc),
    .redir_const (redir_const),
    .redir_addr  (redir_addr),
    .fetch_cnt   (fetch_cnt)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A00_00A5;
  endfunction

  // Memory model + scoreboard. Runs on negedge: inputs driven by tasks at
  // posedge+1 have settled, and decisions here are what the DUT samples
  // at the following posedge.
  always @(negedge clk) begin
    if (rst) begin
      imem_ack     = 1'b0;
      imem_rdata   = 32'hBAD0_0000;
      lat_cnt      = 0;
      drop_pending = 1'b0;
      sb.delete();
    end else begin
      if (instr_valid && dec_ready && !redirect) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL accept_unexpected: got pc=%h word=%h, expected none", InstrPC, InstrReg);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (InstrPC !== e.pc || InstrReg !== e.word) begin
            failures++;
            $display("FAIL accept_data: got pc=%h word=%h, expected pc=%h word=%h",
                     InstrPC, InstrReg, e.pc, e.word);
          end
        end
      end
      if (imem_req && lat_cnt >= mem_lat) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        lat_cnt    = 0;
        ack_log.push_back(imem_addr);
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 32'hBAD0_0000;
        lat_cnt    = imem_req ? lat_cnt + 1 : 0;
      end
      if (redirect) begin
        sb.delete();
        drop_pending = imem_req && !imem_ack;
      end else if (imem_ack) begin
        if (drop_pending) drop_pending = 1'b0;
        else sb.push_back('{pc: imem_addr, word: imem_rdata});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; dec_ready = 1'b0; redirect = 1'b0; redir_sel = 1'b0;
    redir_pc = '0; redir_const = '0; redir_addr = '0;
    tick(2);
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || InstrReg !== 32'h0 ||
        InstrPC !== 32'h0 || fetch_cnt !== 32'h0) begin
      failures++;
      $display("FAIL reset_state: got req=%b vld=%b ir=%h ipc=%h cnt=%0d, expected all 0",
               imem_req, instr_valid, InstrReg, InstrPC, fetch_cnt);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      failures++;
      $display("FAIL idle_bubble: got req=%b, expected 0", imem_req);
    end
  endtask

  task automatic test_sequential;
    int n;
    ack_log.delete();
    mem_lat = 0;
    dec_ready = 1'b1;
    n = 0;
    while (fetch_cnt !== 32'd3 && n < 20) begin
      tick(1);
      n++;
    end
    dec_ready = 1'b0;
    checks++;
    if (fetch_cnt !== 32'd3) begin
      failures++;
      $display("FAIL seq_count: got %0d, expected 3", fetch_cnt);
    end
    checks++;
    if (ack_log.size() < 4 || ack_log[0] !== 32'h0 || ack_log[1] !== 32'h4 ||
        ack_log[2] !== 32'h8 || ack_log[3] !== 32'hC) begin
      failures++;
      $display("FAIL seq_addrs: got %p, expected 0,4,8,c", ack_log);
    end
    checks++;
    if (instr_valid !== 1'b1 || InstrPC !== 32'hC) begin
      failures++;
      $display("FAIL seq_held: got vld=%b pc=%h, expected vld=1 pc=c", instr_valid, InstrPC);
    end
  endtask

  task automatic test_hold;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checks++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b1 ||
          InstrReg !== mem_word(32'hC) || fetch_cnt !== 32'd3) begin
        failures++;
        $display("FAIL hold_stable[%0d]: got req=%b vld=%b ir=%h cnt=%0d, expected req=0 vld=1 ir=%h cnt=3",
                 i, imem_req, instr_valid, InstrReg, fetch_cnt, mem_word(32'hC));
      end
    end
  endtask

  task automatic test_jump;
    // dec_ready high in the redirect cycle: the held word must not count.
    redirect = 1'b1; redir_sel = 1'b1; redir_pc = 32'h0040_0010; redir_addr = 26'h000_0100;
    dec_ready = 1'b1;
    tick(1);
    redirect = 1'b0; dec_ready = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0400 || instr_valid !== 1'b0 ||
        fetch_cnt !== 32'd3) begin
      failures++;
      $display("FAIL jump_redirect: got req=%b addr=%h vld=%b cnt=%0d, expected req=1 addr=00000400 vld=0 cnt=3",
               imem_req, imem_addr, instr_valid, fetch_cnt);
    end
    tick(1);
    checks++;
    if (instr_valid !== 1'b1 || InstrPC !== 32'h400 || InstrReg !== mem_word(32'h400)) begin
      failures++;
      $display("FAIL jump_fetch: got vld=%b pc=%h ir=%h, expected vld=1 pc=400 ir=%h",
               instr_valid, InstrPC, InstrReg, mem_word(32'h400));
    end
  endtask

  task automatic test_branch;
    redirect = 1'b1; redir_sel = 1'b0; redir_pc = 32'h0000_0100; redir_const = 16'hFFFE;
    tick(1);
    redirect = 1'b0;
    checks++;
    if (imem_addr !== 32'h0000_00FC || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL branch_redirect: got addr=%h vld=%b, expected addr=000000fc vld=0",
               imem_addr, instr_valid);
    end
    tick(1);
    checks++;
    if (instr_valid !== 1'b1 || InstrPC !== 32'hFC) begin
      failures++;
      $display("FAIL branch_fetch: got vld=%b pc=%h, expected vld=1 pc=fc", instr_valid, InstrPC);
    end
  endtask

  task automatic test_discard;
    int n;
    mem_lat = 3;
    dec_ready = 1'b1;
    tick(1);
    checks++;
    if (fetch_cnt !== 32'd4 || instr_valid !== 1'b0 || imem_addr !== 32'h100) begin
      failures++;
      $display("FAIL discard_setup: got cnt=%0d vld=%b addr=%h, expected cnt=4 vld=0 addr=100",
               fetch_cnt, instr_valid, imem_addr);
    end
    redirect = 1'b1; redir_sel = 1'b1; redir_pc = 32'h0; redir_addr = 26'h80;
    dec_ready = 1'b0;
    tick(1);
    redirect = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      failures++;
      $display("FAIL discard_old_addr: got req=%b addr=%h, expected req=1 addr=100", imem_req, imem_addr);
    end
    tick(2);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL discard_new_addr: got req=%b addr=%h vld=%b, expected req=1 addr=200 vld=0",
               imem_req, imem_addr, instr_valid);
    end
    n = 0;
    while (instr_valid !== 1'b1 && n < 20) begin
      tick(1);
      n++;
    end
    checks++;
    if (instr_valid !== 1'b1 || InstrPC !== 32'h200 || InstrReg !== mem_word(32'h200)) begin
      failures++;
      $display("FAIL discard_target: got vld=%b pc=%h ir=%h, expected vld=1 pc=200 ir=%h",
               instr_valid, InstrPC, InstrReg, mem_word(32'h200));
    end
  endtask

  task automatic test_back_to_back;
    mem_lat = 0;
    dec_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      checks++;
      if (fetch_cnt !== 32'(4 + k) || instr_valid !== 1'b1 ||
          InstrPC !== 32'(32'h200 + 4 * k)) begin
        failures++;
        $display("FAIL b2b[%0d]: got cnt=%0d vld=%b pc=%h, expected cnt=%0d vld=1 pc=%h",
                 k, fetch_cnt, instr_valid, InstrPC, 4 + k, 32'h200 + 4 * k);
      end
    end
    dec_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    mem_lat = 3;
    dec_ready = 1'b1;
    tick(1);
    dec_ready = 1'b0;
    checks++;
    if (fetch_cnt !== 32'd11 || imem_req !== 1'b1 || imem_addr !== 32'h21C) begin
      failures++;
      $display("FAIL rstmid_setup: got cnt=%0d req=%b addr=%h, expected cnt=11 req=1 addr=21c",
               fetch_cnt, imem_req, imem_addr);
    end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instr_valid !== 1'b0 || fetch_cnt !== 32'h0) begin
      failures++;
      $display("FAIL rstmid_state: got req=%b addr=%h vld=%b cnt=%0d, expected req=0 addr=0 vld=0 cnt=0",
               imem_req, imem_addr, instr_valid, fetch_cnt);
    end
    tick(1);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL rstmid_refetch: got req=%b addr=%h, expected req=1 addr=0", imem_req, imem_addr);
    end
  endtask

  initial begin
    rst = 1'b1; dec_ready = 1'b0; redirect = 1'b0; redir_sel = 1'b0;
    redir_pc = '0; redir_const = '0; redir_addr = '0;
    test_reset();
    test_sequential();
    test_hold();
    test_jump();
    test_branch();
    test_discard();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
